// File: rtl/shift_request_controller.sv
// Request/response sequencer for a multi-cycle 4-bit logical shifter.
// Optional result checking is built when SHIFT_RESULT_CHECK_EN is defined.
module shift_request_controller #(
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_dir,
    input  logic [1:0] in_cnt,
    output logic       sh_rst,
    output logic [3:0] sh_inp,
    output logic       sh_dir,
    output logic [1:0] sh_cnt,
    input  logic [3:0] sh_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Settle cycles beyond the shift count itself; in_cnt is added at accept.
    localparam logic [3:0] WAIT_BASE = 4'(2 + EXTRA_WAIT);

    state_t     state_r;
    logic [3:0] wait_r;
    logic       accept_s;
    logic       release_s;
    logic       err_s;
    logic [3:0] wait_load_s;

`ifdef SHIFT_RESULT_CHECK_EN
    function automatic logic [3:0] expected_shift(
        input logic [3:0] data,
        input logic       dir,
        input logic [1:0] cnt
    );
        logic [3:0] res;
        if (dir) begin
            res = data >> cnt;
        end else begin
            res = data << cnt;
        end
        return res;
    endfunction

    // Compare shifter output with the shift of the latched operand.
    always_comb begin
        err_s = 1'b0;
        if (sh_out != expected_shift(sh_inp, sh_dir, sh_cnt)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end
`else
    assign err_s = 1'b0;
`endif

    // Handshake qualifiers and the run length for a new request.
    always_comb begin
        accept_s    = 1'b0;
        release_s   = 1'b0;
        wait_load_s = {2'b00, in_cnt} + WAIT_BASE;
        if (state_r == IDLE) begin
            accept_s = in_valid & in_ready;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == DONE) begin
            release_s = res_valid & res_ready;
        end else begin
            release_s = 1'b0;
        end
    end

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            wait_r    <= 4'd0;
            in_ready  <= 1'b1;
            sh_rst    <= 1'b1;
            sh_inp    <= 4'd0;
            sh_dir    <= 1'b0;
            sh_cnt    <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= 4'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sh_inp   <= in_data;
                        sh_dir   <= in_dir;
                        sh_cnt   <= in_cnt;
                        wait_r   <= wait_load_s;
                        sh_rst   <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        sh_rst   <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    if (wait_r != 4'd0) begin
                        wait_r <= wait_r - 4'd1;
                    end else begin
                        res_data  <= sh_out;
                        err       <= err_s;
                        sh_rst    <= 1'b1;
                        res_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (release_s) begin
                        res_valid <= 1'b0;
                        err       <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= DONE;
                    end
                end
                default: begin
                    wait_r    <= 4'd0;
                    in_ready  <= 1'b1;
                    sh_rst    <= 1'b1;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    err       <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_request_controller.sv
// Directed, table-driven bench for shift_request_controller with a behavioural shifter.
module tb_shift_request_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic [1:0] in_cnt;
    logic       sh_rst;
    logic [3:0] sh_inp;
    logic       sh_dir;
    logic [1:0] sh_cnt;
    logic [3:0] sh_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       busy;
    logic       err;
    logic       corrupt;

    int tests = 0;
    int failed = 0;

    shift_request_controller #(.EXTRA_WAIT(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dir(in_dir), .in_cnt(in_cnt),
        .sh_rst(sh_rst), .sh_inp(sh_inp), .sh_dir(sh_dir), .sh_cnt(sh_cnt),
        .sh_out(sh_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Shifter model; corrupt forces a wrong answer for one specific request.
    always_comb begin
        if (sh_rst) begin
            sh_out = 4'd0;
        end else if (corrupt && sh_inp == 4'b0011 && !sh_dir && sh_cnt == 2'd1) begin
            sh_out = 4'b1111;
        end else if (sh_dir) begin
            sh_out = sh_inp >> sh_cnt;
        end else begin
            sh_out = sh_inp << sh_cnt;
        end
    end

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [1:0] cnt;
        logic [3:0] exp_res;
        int         exp_lat;
        int         hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_req(input logic [3:0] d, input logic dr, input logic [1:0] c,
                           input int exp_lat, input logic [3:0] exp_res,
                           input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_dir = dr; in_cnt = c;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; in_dir = ~dr; in_cnt = ~c;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("res_data", 32'(res_data), 32'(exp_res));
        chk("err_done", 32'(err), 32'(exp_err));
        chk("ready_low_done", 32'(in_ready), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        chk("sh_inp_stable", 32'(sh_inp), 32'(d));
        chk("sh_rst_done", 32'(sh_rst), 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_data", 32'(res_data), 32'(exp_res));
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(res_valid), 32'd1);
        end
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        chk("release_valid", 32'(res_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        chk("release_err", 32'(err), 32'd0);
    endtask

    logic [3:0] bb_data[4];
    logic [1:0] bb_cnt[4];
    logic [3:0] bb_exp[4];

    initial begin
        logic exp_corrupt_err;
        int idx;
        int got;
        logic acc;
        logic rsp;

        vecs[0] = '{4'b1011, 1'b0, 2'd2, 4'b1100, 5, 0};
        vecs[1] = '{4'b1011, 1'b1, 2'd1, 4'b0101, 4, 10};
        vecs[2] = '{4'b0110, 1'b0, 2'd0, 4'b0110, 3, 0};
        vecs[3] = '{4'b0001, 1'b0, 2'd3, 4'b1000, 6, 0};
        vecs[4] = '{4'b1111, 1'b1, 2'd3, 4'b0001, 6, 0};
        vecs[5] = '{4'b1001, 1'b1, 2'd2, 4'b0010, 5, 0};
        vecs[6] = '{4'b0111, 1'b0, 2'd1, 4'b1110, 4, 0};

        bb_data = '{4'b0011, 4'b1000, 4'b0101, 4'b1110};
        bb_cnt  = '{2'd1, 2'd3, 2'd0, 2'd2};
        bb_exp  = '{4'b0110, 4'b0000, 4'b0101, 4'b1000};

        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_dir = 1'b0; in_cnt = 2'd0;
        res_ready = 1'b0; corrupt = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sh_rst", 32'(sh_rst), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sh_inp", 32'(sh_inp), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].data, vecs[i].dir, vecs[i].cnt, vecs[i].exp_lat,
                    vecs[i].exp_res, 1'b0, vecs[i].hold);
        end

        // Abort a cnt=3 run two edges after accept.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0001; in_dir = 1'b0; in_cnt = 2'd3;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; #1;
        chk("abort_sh_rst", 32'(sh_rst), 32'd1);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(res_valid), 32'd0);
        end
        run_req(4'b1101, 1'b1, 2'd1, 4, 4'b0110, 1'b0, 0);

        // Back-to-back requests with both handshakes held high.
        idx = 0; got = 0;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            if (idx < 4) begin
                in_valid = 1'b1; in_data = bb_data[idx]; in_dir = 1'b0; in_cnt = bb_cnt[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid & in_ready;
            rsp = res_valid;
            if (acc) begin
                chk("bb_accept_idle", 32'({busy, res_valid}), 32'd0);
            end
            if (acc && rsp) begin
                chk("bb_accept_during_done", 32'd1, 32'd0);
            end
            @(posedge clk);
            if (acc) idx++;
            if (rsp) begin
                chk("bb_result", 32'(res_data), 32'(bb_exp[got]));
                got++;
            end
        end
        chk("bb_all_delivered", 32'(got), 32'd4);
        chk("bb_all_accepted", 32'(idx), 32'd4);
        @(negedge clk); in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Corrupted shifter result.
`ifdef SHIFT_RESULT_CHECK_EN
        exp_corrupt_err = 1'b1;
`else
        exp_corrupt_err = 1'b0;
`endif
        corrupt = 1'b1;
        run_req(4'b0011, 1'b0, 2'd1, 4, 4'b1111, exp_corrupt_err, 2);
        corrupt = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/shift_request_controller.md
SHIFT_REQUEST_CONTROLLER -- requirements
Module: shift_request_controller

Interface
REQ-001 Parameter SHALL be: EXTRA_WAIT, default 0, extra settle cycles added to every shift run (legal range 0..10).
REQ-002 Ports SHALL be (name direction width meaning):
 clk  input  1  clock, all state on rising edge
 rst  input  1  reset, asynchronous, active-high
 in_valid  input  1  request present
 in_ready  output  1  request accepted when in_valid & in_ready at clk edge
 in_data  input  4  operand to shift
 in_dir  input  1  0 = left, 1 = right, logical (zero fill)
 in_cnt  input  2  shift count 0..3
 sh_rst  output  1  reset/restart strobe to the multi-cycle shifter, registered
 sh_inp  output  4  operand to shifter, registered
 sh_dir  output  1  direction to shifter, registered
 sh_cnt  output  2  count to shifter, registered
 sh_out  input  4  shifter result
 res_valid  output  1  result available
 res_ready  input  1  result consumed when res_valid & res_ready at clk edge
 res_data  output  4  captured result
 busy  output  1  high in RUN or DONE
 err  output  1  result check mismatch (see Configuration)

Function
REQ-003 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE.
REQ-005 IDLE: sh_rst = 1 (shifter held in reset); on accept edge A, latch in_data/in_dir/in_cnt into sh_inp/sh_dir/sh_cnt, load 4-bit wait counter with in_cnt + 2 + EXTRA_WAIT, drive sh_rst = 0, go RUN.
REQ-006 RUN: wait counter SHALL decrement by 1 per edge while nonzero; at the first edge where it is already 0, capture sh_out into res_data, set sh_rst = 1, go DONE.
REQ-007 Accept-to-res_valid latency SHALL be exactly in_cnt + 3 + EXTRA_WAIT clock edges (in_cnt = 0, EXTRA_WAIT = 0 -> 3 edges).
REQ-008 sh_inp/sh_dir/sh_cnt SHALL remain stable from edge A until the next accept.
REQ-009 DONE: res_data and err SHALL hold; on res_ready edge go IDLE; without res_ready, stay in DONE indefinitely.
REQ-010 in_valid while not IDLE SHALL be ignored (not accepted, no state change); a request present during the DONE->IDLE edge SHALL be accepted no earlier than the following edge.
REQ-011 res_ready while not DONE SHALL be ignored.
REQ-012 Request fields SHALL be sampled only at the accept edge; later changes SHALL have no effect on the run in progress.

Reset
REQ-013 rst SHALL asynchronously force: state IDLE, in_ready 1, sh_rst 1, sh_inp 0, sh_dir 0, sh_cnt 0, wait counter 0, res_valid 0, res_data 0, busy 0, err 0.
REQ-014 rst asserted in RUN or DONE SHALL abort the operation with no result delivered; the first accept after rst release SHALL start a fresh run.

Configuration
REQ-015 Macro SHIFT_RESULT_CHECK_EN defined: at the capture edge the block SHALL compute the expected result (in_data shifted by in_cnt in in_dir, zero fill) and set err = 1 if sh_out differs. err SHALL hold through DONE and clear on the DONE->IDLE edge.
REQ-016 Macro undefined: err SHALL be constant 0 and no checking logic SHALL be present.

Verification
REQ-017 Accept in_data=1011, dir=0, cnt=2 -> res_valid 5 edges after accept, res_data=1100, err=0.
REQ-018 Accept in_data=1011, dir=1, cnt=1 -> res_valid after 4 edges, res_data=0101; hold res_ready=0 for 10 cycles -> res_data stable, in_ready=0 throughout.
REQ-019 Accept cnt=0, data=0110 -> res_valid after 3 edges, res_data=0110; in_cnt=3, dir=0, data=0001 -> res_data=1000.
REQ-020 Assert rst 2 cycles into a cnt=3 run -> res_valid never rises, sh_rst=1 immediately, in_ready=1; next request completes normally.
REQ-021 Back-to-back in_valid held high with res_ready=1 -> each request accepted only in IDLE, results delivered in order, no request dropped.
REQ-022 SHIFT_RESULT_CHECK_EN build, shifter model forced to return 1111 for data=0011, dir=0, cnt=1 -> err=1 while res_valid=1, err=0 after handshake.
